draw_scheduler: RTL and testbench

- Round-robin scheduler that shares the single VGA adapter write port among three pixel-generating sources (e.g. transition screen, background clear, sprite draw).
- Per job: re-arms the granted source with a one-cycle active-low reset, enables it, and muxes its X/Y/colour onto the adapter.
- Clips off-screen coordinates and releases the port when the source raises done, or when a timeout expires.

---
 rtl/draw_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Round-robin owner of the single VGA adapter write port.
// Each job re-arms the granted source with a one-cycle active-low reset,
// enables it, forwards its pixel stream (with off-screen clipping) and
// releases the port on the source's done flag or on a RUN-cycle timeout.
module draw_scheduler #(
    parameter int WIDTH          = 320,
    parameter int HEIGHT         = 240,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  done_in,
    input  logic [26:0] x_in,
    input  logic [26:0] y_in,
    input  logic [8:0]  colour_in,
    output logic [2:0]  src_en,
    output logic [2:0]  src_rst_n,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [2:0]  done_pulse,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, FINISH} state_t;

    localparam logic [9:0]  WIDTH_L      = 10'(WIDTH);
    localparam logic [9:0]  HEIGHT_L     = 10'(HEIGHT);
    localparam logic [17:0] TIMEOUT_LAST = 18'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  g_reg, g_next;
    logic [1:0]  last_reg, last_next;
    logic [17:0] counter_reg, counter_next;
    logic [2:0]  src_en_reg, src_en_next;
    logic [2:0]  src_rst_n_reg, src_rst_n_next;
    logic [8:0]  vga_x_reg, vga_x_next;
    logic [7:0]  vga_y_reg, vga_y_next;
    logic [2:0]  vga_colour_reg, vga_colour_next;
    logic        vga_plot_reg, vga_plot_next;
    logic [2:0]  grant_reg, grant_next;
    logic        busy_reg, busy_next;
    logic [2:0]  done_pulse_reg, done_pulse_next;
    logic        timeout_err_reg, timeout_err_next;

    // Per-source fields unpacked into 4-entry arrays so a 2-bit index is always in range
    logic [8:0] x_arr      [4];
    logic [8:0] y_arr      [4];
    logic [2:0] colour_arr [4];
    logic [3:0] done_vec;
    logic [3:0] req_vec;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign x_arr[gi]      = x_in[9*gi +: 9];
            assign y_arr[gi]      = y_in[9*gi +: 9];
            assign colour_arr[gi] = colour_in[3*gi +: 3];
        end
    endgenerate

    assign x_arr[3]      = '0;
    assign y_arr[3]      = '0;
    assign colour_arr[3] = '0;
    assign done_vec      = {1'b0, done_in};
    assign req_vec       = {1'b0, req};

    logic [1:0] cand1, cand2, pick;
    logic [2:0] pick_onehot;
    logic [8:0] sel_x, sel_y;
    logic [2:0] sel_colour;
    logic       sel_done, in_range;

    // Round-robin pick: search last+1, last+2, last (mod 3); also selects the owner's stream
    always_comb begin
        cand1       = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;
        cand2       = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        pick        = last_reg;
        if (req_vec[cand1]) begin
            pick = cand1;
        end else if (req_vec[cand2]) begin
            pick = cand2;
        end
        pick_onehot = 3'(4'b0001 << pick);
        sel_x       = x_arr[g_reg];
        sel_y       = y_arr[g_reg];
        sel_colour  = colour_arr[g_reg];
        sel_done    = done_vec[g_reg];
        in_range    = ({1'b0, sel_x} < WIDTH_L) && ({1'b0, sel_y} < HEIGHT_L) && !sel_done;
    end

    // Next-state and next-output logic; every output is a register
    always_comb begin
        state_next       = state_reg;
        g_next           = g_reg;
        last_next        = last_reg;
        counter_next     = counter_reg;
        src_en_next      = 3'b000;
        src_rst_n_next   = 3'b111;
        vga_x_next       = vga_x_reg;
        vga_y_next       = vga_y_reg;
        vga_colour_next  = vga_colour_reg;
        vga_plot_next    = 1'b0;
        grant_next       = grant_reg;
        busy_next        = busy_reg;
        done_pulse_next  = 3'b000;
        timeout_err_next = timeout_err_reg;
        case (state_reg)
            IDLE: begin
                grant_next = 3'b000;
                busy_next  = 1'b0;
                if (|req) begin
                    g_next         = pick;
                    grant_next     = pick_onehot;
                    src_rst_n_next = ~pick_onehot;
                    busy_next      = 1'b1;
                    counter_next   = '0;
                    state_next     = ARM;
                end
            end
            ARM: begin
                src_en_next  = grant_reg;
                counter_next = '0;
                state_next   = RUN;
            end
            RUN: begin
                vga_x_next      = sel_x;
                vga_y_next      = sel_y[7:0];
                vga_colour_next = sel_colour;
                counter_next    = counter_reg + 18'd1;
                if (sel_done) begin
                    // Done beats a coincident timeout
                    done_pulse_next = grant_reg;
                    state_next      = FINISH;
                end else if (counter_reg == TIMEOUT_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = FINISH;
                end else begin
                    src_en_next   = grant_reg;
                    vga_plot_next = in_range;
                end
            end
            FINISH: begin
                last_next  = g_reg;
                grant_next = 3'b000;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            g_reg           <= 2'd0;
            last_reg        <= 2'd2;
            counter_reg     <= '0;
            src_en_reg      <= 3'b000;
            src_rst_n_reg   <= 3'b000;
            vga_x_reg       <= '0;
            vga_y_reg       <= '0;
            vga_colour_reg  <= '0;
            vga_plot_reg    <= 1'b0;
            grant_reg       <= 3'b000;
            busy_reg        <= 1'b0;
            done_pulse_reg  <= 3'b000;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            g_reg           <= g_next;
            last_reg        <= last_next;
            counter_reg     <= counter_next;
            src_en_reg      <= src_en_next;
            src_rst_n_reg   <= src_rst_n_next;
            vga_x_reg       <= vga_x_next;
            vga_y_reg       <= vga_y_next;
            vga_colour_reg  <= vga_colour_next;
            vga_plot_reg    <= vga_plot_next;
            grant_reg       <= grant_next;
            busy_reg        <= busy_next;
            done_pulse_reg  <= done_pulse_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign src_en      = src_en_reg;
    assign src_rst_n   = src_rst_n_reg;
    assign vga_x       = vga_x_reg;
    assign vga_y       = vga_y_reg;
    assign vga_colour  = vga_colour_reg;
    assign vga_plot    = vga_plot_reg;
    assign grant       = grant_reg;
    assign busy        = busy_reg;
    assign done_pulse  = done_pulse_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: three scripted pixel sources, randomized requests,
// and a job-level reference model that expands each grant into its expected
// per-cycle output timeline.
module tb_draw_scheduler;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  done_in;
    logic [26:0] x_in, y_in;
    logic [8:0]  colour_in;
    logic [2:0]  src_en, src_rst_n, grant, done_pulse, vga_colour;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic        vga_plot, busy, timeout_err;

    always #5 clock = ~clock;

    draw_scheduler #(.WIDTH(320), .HEIGHT(240), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .req(req), .done_in(done_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .src_en(src_en), .src_rst_n(src_rst_n), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .grant(grant), .busy(busy),
        .done_pulse(done_pulse), .timeout_err(timeout_err)
    );

    // Source scripts: plen points, then done stays high until re-armed
    logic [8:0] px [3][32];
    logic [8:0] py [3][32];
    logic [2:0] pc [3][32];
    int         plen [3] = '{0, 0, 0};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            int step = 0;
            always @(posedge clock) begin
                if (!src_rst_n[gi]) step <= 0;
                else if (src_en[gi]) step <= step + 1;
            end
            assign done_in[gi]          = (step >= plen[gi]);
            assign x_in[9*gi +: 9]      = (step < plen[gi]) ? px[gi][step] : 9'd0;
            assign y_in[9*gi +: 9]      = (step < plen[gi]) ? py[gi][step] : 9'd0;
            assign colour_in[3*gi +: 3] = (step < plen[gi]) ? pc[gi][step] : 3'd0;
        end
    endgenerate

    typedef struct {
        logic [2:0] grant, src_en, src_rst_n, dp;
        logic       busy, plot, terr, pix;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        int         run_idx;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   last_m, njobs, cyc;
    logic terr_m;
    int   checks = 0, passed = 0, failed = 0;

    function automatic rec_t blank(input logic [2:0] rst_n, input logic terr);
        rec_t r;
        r.grant = 3'b000; r.src_en = 3'b000; r.src_rst_n = rst_n; r.dp = 3'b000;
        r.busy = 1'b0; r.plot = 1'b0; r.terr = terr; r.pix = 1'b0;
        r.x = '0; r.y = '0; r.c = '0; r.run_idx = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare();
        chk("status", {17'd0, grant, busy, src_en, src_rst_n, vga_plot, done_pulse, timeout_err},
            {17'd0, cur.grant, cur.busy, cur.src_en, cur.src_rst_n, cur.plot, cur.dp, cur.terr});
        if (cur.pix)
            chk("pixel", {12'd0, vga_x, vga_y, vga_colour}, {12'd0, cur.x, cur.y, cur.c});
    endtask

    function automatic logic [8:0] rnd_coord(input int lim);
        int r = $urandom_range(0, 9);
        if (r == 0) return 9'(lim);
        if (r == 1) return 9'(lim - 1);
        if (r == 2) return 9'($urandom_range(lim + 1, 511));
        return 9'($urandom_range(0, lim - 2));
    endfunction

    // Expand one grant of source g into its full expected timeline
    task automatic start_job(input int g);
        rec_t r;
        logic [2:0] oh = 3'(1 << g);
        int L, R;
        bit normal;
        njobs++;
        if (njobs % 7 == 3) L = T - 1;                    // done coincides with timeout
        else if (njobs % 7 == 5) L = T + $urandom_range(0, 4);  // never done in time
        else L = $urandom_range(0, 20);
        plen[g] = L;
        for (int k = 0; k < 32; k++) begin
            px[g][k] = rnd_coord(320);
            py[g][k] = rnd_coord(240);
            pc[g][k] = 3'($urandom_range(0, 7));
        end
        r = blank(3'b111 ^ oh, terr_m);
        r.grant = oh; r.busy = 1'b1;
        q.push_back(r);
        normal = (L + 1 <= T);
        R = normal ? L + 1 : T;
        for (int j = 1; j <= R; j++) begin
            r = blank(3'b111, terr_m);
            r.grant = oh; r.busy = 1'b1; r.src_en = oh; r.run_idx = j;
            if (j >= 2) begin
                r.pix  = 1'b1;
                r.x    = px[g][j-2];
                r.y    = py[g][j-2][7:0];
                r.c    = pc[g][j-2];
                r.plot = (px[g][j-2] < 9'd320) && (py[g][j-2] < 9'd240);
            end
            q.push_back(r);
        end
        terr_m = terr_m | !normal;
        r = blank(3'b111, terr_m);
        r.grant = oh; r.busy = 1'b1; r.dp = normal ? oh : 3'b000;
        q.push_back(r);
        q.push_back(blank(3'b111, terr_m));
        last_m = g;
    endtask

    task automatic advance();
        if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (req != 3'b000) begin
            int g = last_m;
            for (int k = 3; k >= 1; k--)
                if (req[(last_m + k) % 3]) g = (last_m + k) % 3;
            start_job(g);
            cur = q.pop_front();
        end else begin
            cur = blank(3'b111, terr_m);
        end
    endtask

    task automatic step_cycle(input logic [2:0] forced, input bit use_forced);
        @(negedge clock);
        cyc++;
        compare();
        reset = 1'b1;
        if (use_forced) req = forced;
        else req = ($urandom_range(0, 9) < 2) ? 3'b000 : 3'($urandom_range(1, 7));
        advance();
    endtask

    task automatic model_reset();
        q.delete();
        last_m = 2;
        terr_m = 1'b0;
        cur = blank(3'b000, 1'b0);
    endtask

    initial begin
        njobs = 0; cyc = 0;
        reset = 1'b1; req = 3'b000;
        model_reset();
        #2 reset = 1'b0;
        #1 compare();
        // First grant after reset must go to source 0 when all request
        step_cycle(3'b111, 1'b1);
        for (int i = 0; i < 500; i++) step_cycle(3'b000, 1'b0);

        // Drive to RUN cycle 3 of some job, then reset in the middle of it
        for (int i = 0; i < 300 && cur.run_idx != 3; i++) step_cycle(3'b000, 1'b0);
        chk("mid_job_reached", cur.run_idx, 3);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 model_reset();
        compare();
        // Only source 1 requests after release: it is served first
        step_cycle(3'b010, 1'b1);
        for (int i = 0; i < 300; i++) step_cycle(3'b000, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
